// File: rtl/fpadd_arbiter.sv
// Round-robin front end sharing one pipelined FP adder between two requesters.
// Optional FPADD_ARB_STATS_EN adds saturating grant/stall counters.
module fpadd_arbiter #(
  parameter int LATENCY = 3,
  parameter int WIDTH   = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             add_valid,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic             add_stall,
  input  logic [WIDTH-1:0] add_result,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             busy
`ifdef FPADD_ARB_STATS_EN
  ,
  output logic [15:0]      grant_count0,
  output logic [15:0]      grant_count1,
  output logic [15:0]      stall_count
`endif
);

  logic               last_grant;  // 1: requester 1 won the most recent transfer
  logic               grant0;
  logic               grant1;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_owner;
  logic               last_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (resetN && !add_stall) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign add_valid  = grant0 | grant1;
  assign add_a      = grant0 ? req0_a : (grant1 ? req1_a : '0);
  assign add_b      = grant0 ? req0_b : (grant1 ? req1_b : '0);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!resetN) begin
      last_grant <= 1'b1;
      tag_valid  <= '0;
      tag_owner  <= '0;
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      // The tag pipe mirrors the adder: it advances only when the adder does.
      if (!add_stall) begin
        tag_valid[0] <= add_valid;
        tag_owner[0] <= grant1;
        for (int i = 1; i < LATENCY; i++) begin
          tag_valid[i] <= tag_valid[i-1];
          tag_owner[i] <= tag_owner[i-1];
        end
      end
    end
  end

  assign last_valid  = tag_valid[LATENCY-1] && !add_stall;
  assign rsp0_valid  = last_valid && !tag_owner[LATENCY-1];
  assign rsp1_valid  = last_valid && tag_owner[LATENCY-1];
  assign rsp0_result = rsp0_valid ? add_result : '0;
  assign rsp1_result = rsp1_valid ? add_result : '0;
  assign busy        = |tag_valid;

`ifdef FPADD_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (!resetN) begin
      grant_count0 <= '0;
      grant_count1 <= '0;
      stall_count  <= '0;
    end else begin
      if (grant0 && grant_count0 != 16'hFFFF) grant_count0 <= grant_count0 + 16'd1;
      if (grant1 && grant_count1 != 16'hFFFF) grant_count1 <= grant_count1 + 16'd1;
      if (add_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter with a behavioural adder pipe returning hand-computed sums.
// Define FPADD_ARB_STATS_EN for both files to exercise the statistics counters.
module tb_fpadd_arbiter;

  localparam int LAT = 3;

  logic        clock;
  logic        resetN;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        add_valid;
  logic [31:0] add_a, add_b;
  logic        add_stall;
  logic [31:0] add_result;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        busy;
`ifdef FPADD_ARB_STATS_EN
  logic [15:0] grant_count0, grant_count1, stall_count;
`endif

  fpadd_arbiter #(.LATENCY(LAT), .WIDTH(32)) dut (
    .clock       (clock),
    .resetN      (resetN),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .add_valid   (add_valid),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_stall   (add_stall),
    .add_result  (add_result),
    .rsp0_valid  (rsp0_valid),
    .rsp0_result (rsp0_result),
    .rsp1_valid  (rsp1_valid),
    .rsp1_result (rsp1_result),
    .busy        (busy)
`ifdef FPADD_ARB_STATS_EN
    ,
    .grant_count0(grant_count0),
    .grant_count1(grant_count1),
    .stall_count (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-computed single-precision sums for the operand pairs used below.
  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h3F800000}: fp_sum = 32'h40000000;  // 1.0 + 1.0
      {32'h3F800000, 32'h40000000}: fp_sum = 32'h40400000;  // 1.0 + 2.0
      {32'h40000000, 32'h40000000}: fp_sum = 32'h40800000;  // 2.0 + 2.0
      {32'h40400000, 32'h3F800000}: fp_sum = 32'h40800000;  // 3.0 + 1.0
      {32'h3F000000, 32'h3F000000}: fp_sum = 32'h3F800000;  // 0.5 + 0.5
      {32'h3FC00000, 32'h3FC00000}: fp_sum = 32'h40400000;  // 1.5 + 1.5
      {32'h3F000000, 32'h3FC00000}: fp_sum = 32'h40000000;  // 0.5 + 1.5
      default:                      fp_sum = 32'hDEADBEEF;
    endcase
  endfunction

  // Shared adder model: reset with the arbiter, frozen by add_stall.
  logic [31:0] add_pipe [LAT];
  always @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < LAT; i++) add_pipe[i] <= 32'h0;
    end else if (!add_stall) begin
      add_pipe[0] <= add_valid ? fp_sum(add_a, add_b) : 32'h0;
      for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign add_result = add_pipe[LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    resetN     = 1'b0;
    add_stall  = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a     = 32'h3F800000;
    req0_b     = 32'h40000000;
    req1_a     = 32'h3F000000;
    req1_b     = 32'h3F000000;
    repeat (2) next_cycle();
    settle();
    check("rst req0_ready", 32'(req0_ready), 32'd0);
    check("rst req1_ready", 32'(req1_ready), 32'd0);
    check("rst add_valid",  32'(add_valid),  32'd0);
    check("rst add_a",      add_a,           32'h0);
    check("rst rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst busy",       32'(busy),       32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next_cycle();
    resetN = 1'b1;
  endtask

  // Contention vectors: requester 0 pairs, requester 1 pairs, expected results in issue order.
  logic [31:0] a0 [4];
  logic [31:0] b0 [4];
  logic [31:0] a1 [3];
  logic [31:0] b1 [3];
  logic [31:0] t2_res [6];

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0, i1, k;
    a0 = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000};
    b0 = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000};
    a1 = '{32'h3F000000, 32'h3FC00000, 32'h3F000000};
    b1 = '{32'h3F000000, 32'h3FC00000, 32'h3FC00000};
    t2_res = '{32'h40000000, 32'h3F800000, 32'h40400000,
               32'h40400000, 32'h40800000, 32'h40000000};

    // Single request from requester 0: 1.0 + 2.0 returns 3.0 three cycles later.
    do_reset();
    req0_valid = 1'b1;
    req0_a     = 32'h3F800000;
    req0_b     = 32'h40000000;
    settle();
    check("t1 req0_ready", 32'(req0_ready), 32'd1);
    check("t1 req1_ready", 32'(req1_ready), 32'd0);
    check("t1 add_valid",  32'(add_valid),  32'd1);
    check("t1 add_a",      add_a,           32'h3F800000);
    check("t1 add_b",      add_b,           32'h40000000);
    next_cycle();
    req0_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      settle();
      check($sformatf("t1 rsp0_valid c%0d", c),  32'(rsp0_valid), 32'(c == 3));
      check($sformatf("t1 rsp0_result c%0d", c), rsp0_result, (c == 3) ? 32'h40400000 : 32'h0);
      check($sformatf("t1 rsp1_valid c%0d", c),  32'(rsp1_valid), 32'd0);
      check($sformatf("t1 busy c%0d", c),        32'(busy),       32'(c <= 3));
      next_cycle();
    end

    // Both requesters valid for 6 cycles: strict alternation starting with requester 0.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      i0 = (c + 1) / 2;
      i1 = c / 2;
      req0_valid = (c < 6);
      req1_valid = (c < 6);
      if (c < 6) begin
        req0_a = a0[i0];
        req0_b = b0[i0];
        req1_a = a1[i1];
        req1_b = b1[i1];
      end
      settle();
      check($sformatf("t2 req0_ready c%0d", c), 32'(req0_ready), 32'(c < 6 && c % 2 == 0));
      check($sformatf("t2 req1_ready c%0d", c), 32'(req1_ready), 32'(c < 6 && c % 2 == 1));
      if (c < 6) begin
        check($sformatf("t2 add_a c%0d", c), add_a, (c % 2 == 0) ? a0[i0] : a1[i1]);
        check($sformatf("t2 add_b c%0d", c), add_b, (c % 2 == 0) ? b0[i0] : b1[i1]);
      end
      if (c >= 3) begin
        k = c - 3;
        check($sformatf("t2 rsp0_valid c%0d", c), 32'(rsp0_valid), 32'(k % 2 == 0));
        check($sformatf("t2 rsp1_valid c%0d", c), 32'(rsp1_valid), 32'(k % 2 == 1));
        check($sformatf("t2 rsp_result c%0d", c),
              (k % 2 == 0) ? rsp0_result : rsp1_result, t2_res[k]);
      end else begin
        check($sformatf("t2 rsp0_valid c%0d", c), 32'(rsp0_valid), 32'd0);
        check($sformatf("t2 rsp1_valid c%0d", c), 32'(rsp1_valid), 32'd0);
      end
      next_cycle();
    end

    // Two-cycle stall while requester 1's operation is in flight delays it by two.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      req1_valid = (c == 0);
      req1_a     = 32'h3F800000;
      req1_b     = 32'h40000000;
      add_stall  = (c == 1 || c == 2);
      settle();
      if (c == 0) check("t3 req1_ready c0", 32'(req1_ready), 32'd1);
      check($sformatf("t3 rsp1_valid c%0d", c),  32'(rsp1_valid), 32'(c == 5));
      check($sformatf("t3 rsp1_result c%0d", c), rsp1_result, (c == 5) ? 32'h40400000 : 32'h0);
      check($sformatf("t3 rsp0_valid c%0d", c),  32'(rsp0_valid), 32'd0);
      if (c >= 1) check($sformatf("t3 busy c%0d", c), 32'(busy), 32'(c <= 5));
      next_cycle();
    end
    add_stall = 1'b0;

    // Stall at request time: no handshake until the stall drops.
    do_reset();
    req0_valid = 1'b1;
    req0_a     = 32'h3F800000;
    req0_b     = 32'h3F800000;
    add_stall  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("t4 req0_ready c%0d", c), 32'(req0_ready), 32'd0);
      check($sformatf("t4 add_valid c%0d", c),  32'(add_valid),  32'd0);
      check($sformatf("t4 add_a c%0d", c),      add_a,           32'h0);
      next_cycle();
    end
    add_stall = 1'b0;
    settle();
    check("t4 req0_ready c3", 32'(req0_ready), 32'd1);
    check("t4 add_valid c3",  32'(add_valid),  32'd1);
    check("t4 add_a c3",      add_a,           32'h3F800000);
    next_cycle();
    req0_valid = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      settle();
      check($sformatf("t4 rsp0_valid c%0d", c),  32'(rsp0_valid), 32'(c == 6));
      check($sformatf("t4 rsp0_result c%0d", c), rsp0_result, (c == 6) ? 32'h40000000 : 32'h0);
      next_cycle();
    end

    // Reset while two operations are in flight discards both.
    do_reset();
    req0_valid = 1'b1;
    req0_a     = 32'h3F800000;
    req0_b     = 32'h3F800000;
    settle();
    check("t5 req0_ready c0", 32'(req0_ready), 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_a     = 32'h3F000000;
    req1_b     = 32'h3F000000;
    settle();
    check("t5 req1_ready c1", 32'(req1_ready), 32'd1);
    next_cycle();
    resetN     = 1'b0;
    settle();
    check("t5 req1_ready c2", 32'(req1_ready), 32'd0);
    check("t5 add_valid c2",  32'(add_valid),  32'd0);
    req1_valid = 1'b0;
    next_cycle();
    resetN = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      settle();
      check($sformatf("t5 rsp0_valid c%0d", c), 32'(rsp0_valid), 32'd0);
      check($sformatf("t5 rsp1_valid c%0d", c), 32'(rsp1_valid), 32'd0);
      check($sformatf("t5 busy c%0d", c),       32'(busy),       32'd0);
      next_cycle();
    end

`ifdef FPADD_ARB_STATS_EN
    // 5 transfers from requester 0, 3 from requester 1, 2 stalled cycles.
    do_reset();
    req0_a = 32'h3F800000;
    req0_b = 32'h3F800000;
    req1_a = 32'h3F000000;
    req1_b = 32'h3F000000;
    for (int c = 0; c < 10; c++) begin
      req0_valid = (c < 5) || (c >= 8);
      req1_valid = (c >= 5 && c < 8);
      add_stall  = (c >= 8);
      next_cycle();
    end
    req0_valid = 1'b0;
    add_stall  = 1'b0;
    settle();
    check("stats grant_count0", 32'(grant_count0), 32'd5);
    check("stats grant_count1", 32'(grant_count1), 32'd3);
    check("stats stall_count",  32'(stall_count),  32'd2);
    next_cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
